// File: rtl/jtgng_rom_arb.sv
// ---------------------------------------------------------------------------
// jtgng_rom_arb
//
// Read arbiter between CLIENTS ROM clients (main CPU, sound CPU, char, scroll,
// obj, ...) and a single SDRAM read port. Each client has a one-word cache
// (tag/data/valid). Misses are scheduled round-robin, optionally with client 0
// winning whenever it is pending. A ROM download invalidates every cache and
// stalls arbitration.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   downloading  ROM download in progress: blocks arbitration, clears caches
//   req          per-client level request, held with addr until ok
//   addr         per-client word address, client i at [i*AW +: AW]
//   ok           per-client registered hit flag for the current addr
//   dout         per-client cached word, client i at [i*DW +: DW]
//   sdram_rd     read command to the SDRAM controller (held until ack)
//   sdram_addr   read address, also the tag of the transaction in flight
//   sdram_ack    controller accepted the command this cycle
//   sdram_dv     sdram_data valid this cycle (one pulse per accepted read)
//   sdram_data   read data
// ---------------------------------------------------------------------------
module jtgng_rom_arb #(
    parameter int CLIENTS = 5,
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int PRIO0   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [CLIENTS-1:0]    req,
    input  logic [CLIENTS*AW-1:0] addr,
    output logic [CLIENTS-1:0]    ok,
    output logic [CLIENTS*DW-1:0] dout,
    output logic                  sdram_rd,
    output logic [AW-1:0]         sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  sdram_dv,
    input  logic [DW-1:0]         sdram_data
);

    localparam int GW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       winner;
    logic [GW-1:0]       cand;
    logic                found;
    logic                fill;
    logic [CLIENTS-1:0]  hit;
    logic [CLIENTS-1:0]  pending;
    logic [AW-1:0]       addr_arr [CLIENTS];

    // Data capture strobe; sdram_dv outside WAIT never reaches a cache.
    assign fill = (state == WAIT) && sdram_dv;

    // -----------------------------------------------------------------------
    // Per-client cache
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < CLIENTS; i++) begin : g_client
        logic [AW-1:0] tag_q;
        logic [DW-1:0] data_q;
        logic          valid_q;
        logic          ok_q;
        logic [AW-1:0] caddr;
        logic          mine;
        logic          in_flight;

        assign caddr       = addr[i*AW +: AW];
        assign addr_arr[i] = caddr;
        assign mine        = (grant == GW'(i));
        assign hit[i]      = req[i] & valid_q & (tag_q == caddr);

        // sdram_addr holds the issued address for the whole ISSUE/WAIT span,
        // so it doubles as the in-flight tag. A client whose address moved
        // away from it is pending again and re-arbitrates after the fill.
        assign in_flight   = (state != IDLE) & mine & (sdram_addr == caddr);
        assign pending[i]  = req[i] & ~hit[i] & ~in_flight;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                ok_q    <= 1'b0;
            end else begin
                ok_q <= hit[i];
                if (downloading) begin
                    // Fills landing during a download are dropped entirely.
                    valid_q <= 1'b0;
                end else if (fill && mine) begin
                    tag_q   <= sdram_addr;
                    data_q  <= sdram_data;
                    valid_q <= 1'b1;
                end
            end
        end

        assign ok[i]            = ok_q;
        assign dout[i*DW +: DW] = data_q;
    end

    // -----------------------------------------------------------------------
    // Winner selection: optional client-0 priority, otherwise the first
    // pending client scanning upward from last_grant+1 with wrap-around.
    // -----------------------------------------------------------------------
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = '0;
        if (PRIO0 != 0 && pending[0]) begin
            winner = '0;
            found  = 1'b1;
        end
        for (int unsigned k = 1; k <= CLIENTS; k++) begin
            cand = GW'((32'(last_grant) + k) % CLIENTS);
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM: one outstanding read at a time
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(CLIENTS - 1);
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!downloading && (|pending)) begin
                        grant      <= winner;
                        last_grant <= winner;
                        sdram_addr <= addr_arr[winner];
                        sdram_rd   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sdram_ack) begin
                        sdram_rd <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (sdram_dv) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sdram_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtgng_rom_arb.sv
module tb_jtgng_rom_arb;

    localparam int CLIENTS = 5;
    localparam int AW      = 22;
    localparam int DW      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  downloading;
    logic [CLIENTS-1:0]    req;
    logic [AW-1:0]         a_arr [CLIENTS];
    logic [CLIENTS*AW-1:0] addr_bus;

    // index 0: PRIO0=1 instance, index 1: PRIO0=0 instance
    logic [CLIENTS-1:0]    ok    [2];
    logic [CLIENTS*DW-1:0] dout  [2];
    logic                  rd    [2];
    logic [AW-1:0]         saddr [2];
    logic                  ack   [2];
    logic                  dv    [2];
    logic [DW-1:0]         sdata [2];

    int            n_checks;
    int            n_fail;
    int            dv_delay;
    int            ph    [2];
    int            cnt   [2];
    int            fills [2];
    logic [AW-1:0] raddr [2];
    logic [AW-1:0] log0 [$];
    logic [AW-1:0] log1 [$];

    always_comb begin
        addr_bus = '0;
        for (int c = 0; c < CLIENTS; c++) addr_bus[c*AW +: AW] = a_arr[c];
    end

    jtgng_rom_arb #(.CLIENTS(CLIENTS), .AW(AW), .DW(DW), .PRIO0(1)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .req(req), .addr(addr_bus),
        .ok(ok[0]), .dout(dout[0]), .sdram_rd(rd[0]), .sdram_addr(saddr[0]),
        .sdram_ack(ack[0]), .sdram_dv(dv[0]), .sdram_data(sdata[0])
    );

    jtgng_rom_arb #(.CLIENTS(CLIENTS), .AW(AW), .DW(DW), .PRIO0(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .req(req), .addr(addr_bus),
        .ok(ok[1]), .dout(dout[1]), .sdram_rd(rd[1]), .sdram_addr(saddr[1]),
        .sdram_ack(ack[1]), .sdram_dv(dv[1]), .sdram_data(sdata[1])
    );

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        if (a == 22'h01234) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic int log_size(input int d);
        return (d == 0) ? log0.size() : log1.size();
    endfunction

    function automatic logic [AW-1:0] log_at(input int d, input int i);
        if (i >= log_size(d)) return '1;
        return (d == 0) ? log0[i] : log1[i];
    endfunction

    function automatic logic [DW-1:0] dout_of(input int d, input int c);
        return dout[d][c*DW +: DW];
    endfunction

    // SDRAM model: ack on the first negedge sdram_rd is seen, dv dv_delay
    // negedges later. Logs every issued address per instance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                ph[d] = 0; ack[d] = 1'b0; dv[d] = 1'b0; sdata[d] = '0; fills[d] = 0;
                if (d == 0) log0.delete(); else log1.delete();
            end else begin
                case (ph[d])
                    0: begin
                        if (rd[d]) begin
                            ack[d]   = 1'b1;
                            raddr[d] = saddr[d];
                            if (d == 0) log0.push_back(saddr[d]); else log1.push_back(saddr[d]);
                            cnt[d] = dv_delay;
                            ph[d]  = 1;
                        end
                    end
                    1: begin
                        ack[d] = 1'b0;
                        cnt[d] = cnt[d] - 1;
                        if (cnt[d] <= 0) begin
                            dv[d]    = 1'b1;
                            sdata[d] = fdata(raddr[d]);
                            fills[d] = fills[d] + 1;
                            ph[d]    = 2;
                        end
                    end
                    default: begin
                        dv[d] = 1'b0;
                        ph[d] = 0;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        req = '0;
        downloading = 1'b0;
        for (int c = 0; c < CLIENTS; c++) a_arr[c] = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_issues(input int d, input int n, input string name);
        for (int t = 0; t < 400; t++) begin
            if (log_size(d) >= n) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, dut%0d issued %0d reads, required %0d", name, d, log_size(d), n);
    endtask

    task automatic wait_fills(input int d, input int n, input string name);
        for (int t = 0; t < 400; t++) begin
            if (fills[d] >= n) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, dut%0d saw %0d fills, required %0d", name, d, fills[d], n);
    endtask

    task automatic test_reset();
        logic [AW-1:0] exp;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (ok[0] !== 5'h00 || rd[0] !== 1'b0 || saddr[0] !== 22'h0 || dout[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ok=%h rd=%b addr=%h dout=%h, required all zero", ok[0], rd[0], saddr[0], dout[0]);
        end
        rst_n = 1'b1;
        step();
        dv_delay = 2;
        for (int c = 0; c < CLIENTS; c++) a_arr[c] = 22'((c << 8) | 8'h11);
        req = 5'h1F;
        wait_fills(0, 5, "reset_fill_all");
        step();
        step();
        n_checks++;
        if (ok[0] !== 5'h1F) begin
            n_fail++;
            $display("FAIL reset_all_hit: ok=%h required %h", ok[0], 5'h1F);
        end
        for (int c = 0; c < CLIENTS; c++) begin
            exp = 22'((c << 8) | 8'h11);
            n_checks++;
            if (log_at(0, c) !== exp) begin
                n_fail++;
                $display("FAIL reset_issue_order[%0d]: addr=%h required %h", c, log_at(0, c), exp);
            end
        end
        a_arr[4] = 22'h4FF;
        dv_delay = 6;
        wait_issues(0, 6, "reset_refetch4");
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ok[0] !== 5'h00 || rd[0] !== 1'b0 || dout[0] !== '0 || saddr[0] !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_async: ok=%h rd=%b dout=%h addr=%h, required all zero", ok[0], rd[0], dout[0], saddr[0]);
        end
        step();
        step();
        rst_n = 1'b1;
        wait_issues(0, 1, "reset_first_issue");
        wait_issues(1, 1, "reset_first_issue_rr");
        n_checks++;
        if (log_at(0, 0) !== 22'h011 || log_at(1, 0) !== 22'h011) begin
            n_fail++;
            $display("FAIL reset_first_client0: prio=%h rr=%h required %h", log_at(0, 0), log_at(1, 0), 22'h011);
        end
    endtask

    task automatic test_miss_hit();
        clear_all();
        dv_delay = 4;
        a_arr[2] = 22'h01234;
        req = 5'b00100;
        wait_fills(0, 1, "miss_fill");
        n_checks++;
        if (log_at(0, 0) !== 22'h01234 || ok[0][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_issue: addr=%h ok2=%b, required %h and 0", log_at(0, 0), ok[0][2], 22'h01234);
        end
        step();
        n_checks++;
        if (ok[0][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_ok_latency: ok2=%b required 0 on capture cycle", ok[0][2]);
        end
        step();
        n_checks++;
        if (ok[0][2] !== 1'b1 || dout_of(0, 2) !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL miss_ok: ok2=%b dout2=%h, required 1 and BEEF", ok[0][2], dout_of(0, 2));
        end
        req = 5'b00000;
        step();
        n_checks++;
        if (ok[0][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_req_drop: ok2=%b required 0", ok[0][2]);
        end
        req = 5'b00100;
        step();
        n_checks++;
        if (ok[0][2] !== 1'b1 || rd[0] !== 1'b0 || log_size(0) != 1) begin
            n_fail++;
            $display("FAIL hit_rerequest: ok2=%b rd=%b reads=%0d, required 1, 0, 1", ok[0][2], rd[0], log_size(0));
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp [3];
        clear_all();
        dv_delay = 2;
        a_arr[1] = 22'h100; a_arr[3] = 22'h300; a_arr[4] = 22'h400;
        req = 5'b11010;
        wait_issues(1, 3, "rr_round1");
        exp = '{22'h100, 22'h300, 22'h400};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_at(1, i) !== exp[i] || log_at(0, i) !== exp[i]) begin
                n_fail++;
                $display("FAIL rr_order1[%0d]: rr=%h prio=%h required %h", i, log_at(1, i), log_at(0, i), exp[i]);
            end
        end
        wait_fills(1, 3, "rr_round1_fill");
        step();
        req = 5'b01000;
        a_arr[3] = 22'h301;
        wait_issues(1, 4, "rr_single3");
        wait_fills(1, 4, "rr_single3_fill");
        step();
        a_arr[1] = 22'h101; a_arr[3] = 22'h302; a_arr[4] = 22'h401;
        req = 5'b11010;
        wait_issues(1, 7, "rr_round2");
        exp = '{22'h401, 22'h101, 22'h302};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_at(1, 4 + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL rr_order2[%0d]: addr=%h required %h", i, log_at(1, 4 + i), exp[i]);
            end
        end
    endtask

    task automatic prio_phase(input int d, input logic [AW-1:0] base0, input logic [AW-1:0] base1);
        clear_all();
        dv_delay = 2;
        a_arr[0] = base0;
        a_arr[1] = base1;
        req = 5'b00011;
        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 100; t++) begin
                step();
                if (dv[d]) break;
            end
            n_checks++;
            if (dv[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_dv_timeout: dut%0d round %0d no fill", d, r);
            end
            // Move the filled client to a fresh address before IDLE re-arbitrates.
            if (a_arr[0] == raddr[d]) a_arr[0] = a_arr[0] + 22'd1;
            else if (a_arr[1] == raddr[d]) a_arr[1] = a_arr[1] + 22'd1;
        end
        step();
    endtask

    task automatic test_priority();
        logic [AW-1:0] exp [4];
        prio_phase(0, 22'h0A0, 22'h1A0);
        exp = '{22'h0A0, 22'h0A1, 22'h0A2, 22'h0A3};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_at(0, i) !== exp[i]) begin
                n_fail++;
                $display("FAIL prio0_grant[%0d]: addr=%h required %h", i, log_at(0, i), exp[i]);
            end
        end
        prio_phase(1, 22'h0B0, 22'h1B0);
        exp = '{22'h0B0, 22'h1B0, 22'h0B1, 22'h1B1};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_at(1, i) !== exp[i]) begin
                n_fail++;
                $display("FAIL rr_alternate[%0d]: addr=%h required %h", i, log_at(1, i), exp[i]);
            end
        end
    endtask

    task automatic test_addr_change();
        clear_all();
        dv_delay = 4;
        a_arr[1] = 22'h010;
        req = 5'b00010;
        wait_issues(0, 1, "chg_issue1");
        step();
        a_arr[1] = 22'h020;
        wait_fills(0, 1, "chg_fill1");
        step();
        step();
        n_checks++;
        if (ok[0][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_stale_ok: ok1=%b required 0", ok[0][1]);
        end
        wait_issues(0, 2, "chg_issue2");
        n_checks++;
        if (log_at(0, 1) !== 22'h020) begin
            n_fail++;
            $display("FAIL chg_reissue: addr=%h required %h", log_at(0, 1), 22'h020);
        end
        wait_fills(0, 2, "chg_fill2");
        step();
        step();
        n_checks++;
        if (ok[0][1] !== 1'b1 || dout_of(0, 1) !== 16'h5A7A) begin
            n_fail++;
            $display("FAIL chg_ok: ok1=%b dout1=%h, required 1 and 5a7a", ok[0][1], dout_of(0, 1));
        end
        // request dropped mid-flight: fill is still cached
        a_arr[1] = 22'h030;
        wait_issues(0, 3, "drop_issue");
        step();
        req = 5'b00000;
        wait_fills(0, 3, "drop_fill");
        step();
        step();
        n_checks++;
        if (ok[0][1] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_ok: ok1=%b required 0", ok[0][1]);
        end
        req = 5'b00010;
        step();
        n_checks++;
        if (ok[0][1] !== 1'b1 || log_size(0) != 3) begin
            n_fail++;
            $display("FAIL drop_cached: ok1=%b reads=%0d, required 1 and 3", ok[0][1], log_size(0));
        end
    endtask

    task automatic test_download();
        logic [AW-1:0] exp [3];
        clear_all();
        dv_delay = 2;
        a_arr[0] = 22'h0C0; a_arr[2] = 22'h2C0;
        req = 5'b00101;
        wait_fills(0, 2, "dl_prefill");
        step();
        step();
        n_checks++;
        if (ok[0] !== 5'b00101) begin
            n_fail++;
            $display("FAIL dl_prefill_ok: ok=%h required %h", ok[0], 5'b00101);
        end
        dv_delay = 6;
        a_arr[3] = 22'h3C0;
        req = 5'b01101;
        wait_issues(0, 3, "dl_issue3");
        step();
        step();
        downloading = 1'b1;
        wait_fills(0, 3, "dl_fill3");
        step();
        step();
        n_checks++;
        if (ok[0] !== 5'h00 || ok[1] !== 5'h00) begin
            n_fail++;
            $display("FAIL dl_ok_clear: prio=%h rr=%h required 00", ok[0], ok[1]);
        end
        for (int t = 0; t < 8; t++) begin
            step();
            n_checks++;
            if (rd[0] !== 1'b0 || log_size(0) != 3) begin
                n_fail++;
                $display("FAIL dl_blocked: rd=%b reads=%0d, required 0 and 3", rd[0], log_size(0));
            end
        end
        downloading = 1'b0;
        wait_issues(0, 6, "dl_refetch");
        wait_issues(1, 6, "dl_refetch_rr");
        exp = '{22'h0C0, 22'h2C0, 22'h3C0};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_at(0, 3 + i) !== exp[i] || log_at(1, 3 + i) !== exp[i]) begin
                n_fail++;
                $display("FAIL dl_refetch_order[%0d]: prio=%h rr=%h required %h", i, log_at(0, 3 + i), log_at(1, 3 + i), exp[i]);
            end
        end
        wait_fills(0, 6, "dl_refill");
        step();
        step();
        n_checks++;
        if (ok[0] !== 5'b01101) begin
            n_fail++;
            $display("FAIL dl_refill_ok: ok=%h required %h", ok[0], 5'b01101);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        dv_delay    = 2;
        rst_n       = 1'b0;
        downloading = 1'b0;
        req         = '0;
        for (int c = 0; c < CLIENTS; c++) a_arr[c] = '0;
        test_reset();
        test_miss_hit();
        test_round_robin();
        test_priority();
        test_addr_change();
        test_download();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
